// File: rtl/led_pulse_driver_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : led_pulse_driver_pkg                                    |
// | Purpose : Shared state encoding and sizing helpers for the LED    |
// |           output drivers.                                         |
// | Rev     : 1.0                                                      |
// +------------------------------------------------------------------+
package led_pulse_driver_pkg;

  // Encoding is fixed so sibling output drivers decode the same values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer wide enough for the longer phase; never narrower than one bit
  // so a 1-cycle ON/GAP configuration still yields a legal vector.
  function automatic int timer_width(input int on_cycles, input int gap_cycles);
    int w;
    w = $clog2(max_of(on_cycles, gap_cycles));
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pulse_driver_cycle_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : led_pulse_driver_cycle_timer                            |
// | Purpose : Loadable down-counter with a zero flag. Holds at zero   |
// |           rather than wrapping.                                   |
// | Rev     : 1.0                                                      |
// +------------------------------------------------------------------+
module led_pulse_driver_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/led_pulse_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : led_pulse_driver                                        |
// | Purpose : Turns one-cycle event flags into visible LED pulses,    |
// |           each followed by a forced dark gap. Events arriving     |
// |           mid-pulse are queued in a saturating counter.           |
// | Rev     : 1.0                                                      |
// +------------------------------------------------------------------+
module led_pulse_driver
  import led_pulse_driver_pkg::*;
#(
  parameter bit INVERT      = 1'b1,
  parameter int ON_CYCLES   = 5_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int MAX_PENDING = 15
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               event_flag,
  output logic                               led_signal,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow_flag
);

  localparam int            PW         = $clog2(MAX_PENDING + 1);
  localparam int            TW         = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] C_ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] C_GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] C_PEND_MAX = PW'(MAX_PENDING);
  localparam bit            C_LIT      = !INVERT;
  localparam bit            C_DARK     = INVERT;

  led_state_t        r_state;
  logic              w_demand;
  logic              w_consume;
  logic              w_timer_load;
  logic [TW-1:0]     w_timer_value;
  logic              w_timer_zero;

  // A new pulse may start whenever there is a live flag or a queued event.
  assign w_demand = event_flag || (pending != '0);

  led_pulse_driver_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_timer_load),
    .load_value (w_timer_value),
    .zero       (w_timer_zero)
  );

  // Decode when a pulse starts (consume) and what the timer reloads with.
  always_comb begin
    w_consume     = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_value = C_ON_LOAD;
    case (r_state)
      IDLE: begin
        if (w_demand) begin
          w_consume    = 1'b1;
          w_timer_load = 1'b1;
        end
      end
      ON: begin
        if (w_timer_zero) begin
          w_timer_load  = 1'b1;
          w_timer_value = C_GAP_LOAD;
        end
      end
      GAP: begin
        if (w_timer_zero && w_demand) begin
          w_consume    = 1'b1;
          w_timer_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Phase sequencing with LED drive and busy registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      led_signal <= C_DARK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_consume) begin
            r_state    <= ON;
            busy       <= 1'b1;
            led_signal <= C_LIT;
          end
        end
        ON: begin
          if (w_timer_zero) begin
            r_state    <= GAP;
            led_signal <= C_DARK;
          end
        end
        GAP: begin
          if (w_timer_zero) begin
            if (w_consume) begin
              // Straight into the next pulse: no IDLE cycle in between.
              r_state    <= ON;
              led_signal <= C_LIT;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          busy       <= 1'b0;
          led_signal <= C_DARK;
        end
      endcase
    end
  end

  // Saturating queue of events not yet started; a flag coinciding with a
  // consume is serviced directly and leaves the count untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      overflow_flag <= 1'b0;
    end else begin
      overflow_flag <= 1'b0;
      if (event_flag && !w_consume) begin
        if (pending == C_PEND_MAX) begin
          overflow_flag <= 1'b1;
        end else begin
          pending <= pending + PW'(1);
        end
      end else if (!event_flag && w_consume) begin
        pending <= pending - PW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_led_pulse_driver                                     |
// | Purpose : Self-checking bench; expected outputs come from a       |
// |           schedule of pulse start times per accepted event.       |
// | Rev     : 1.0                                                      |
// +------------------------------------------------------------------+
module tb_led_pulse_driver;

  localparam bit INVERT      = 1'b1;
  localparam int ON_CYCLES   = 3;
  localparam int GAP_CYCLES  = 2;
  localparam int MAX_PENDING = 3;
  localparam int PERIOD      = ON_CYCLES + GAP_CYCLES;

  logic       clock;
  logic       reset_n;
  logic       event_flag;
  logic       led_signal;
  logic       busy;
  logic [1:0] pending;
  logic       overflow_flag;

  int checks;
  int errors;

  // Reference model: start edge of every accepted event still relevant.
  int         starts[$];
  int         next_free;
  int         cyc;
  logic       exp_led;
  logic       exp_busy;
  logic [1:0] exp_pend;
  logic       exp_ovf;

  led_pulse_driver #(
    .INVERT      (INVERT),
    .ON_CYCLES   (ON_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .event_flag    (event_flag),
    .led_signal    (led_signal),
    .busy          (busy),
    .pending       (pending),
    .overflow_flag (overflow_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    starts.delete();
    next_free = 0;
    exp_led   = INVERT;
    exp_busy  = 1'b0;
    exp_pend  = 2'd0;
    exp_ovf   = 1'b0;
  endtask

  // An event seen at edge cyc starts a pulse at the first free slot. If it
  // must wait and MAX_PENDING events are already waiting, it is dropped.
  task automatic model_edge(input bit ev);
    int  st;
    int  waiting;
    int  pc;
    bit  lit;
    bit  bz;
    bit  drop;
    drop = 1'b0;
    if (ev) begin
      st = (next_free > cyc) ? next_free : cyc;
      waiting = 0;
      foreach (starts[i]) if (starts[i] > cyc) waiting++;
      if (st > cyc && waiting >= MAX_PENDING) begin
        drop = 1'b1;
      end else begin
        starts.push_back(st);
        next_free = st + PERIOD;
      end
    end
    lit = 1'b0; bz = 1'b0; pc = 0;
    foreach (starts[i]) begin
      if (starts[i] <= cyc && cyc < starts[i] + ON_CYCLES) lit = 1'b1;
      if (starts[i] <= cyc && cyc < starts[i] + PERIOD)    bz  = 1'b1;
      if (starts[i] > cyc) pc++;
    end
    exp_led  = INVERT ? !lit : lit;
    exp_busy = bz;
    exp_pend = 2'(pc);
    exp_ovf  = drop;
    while (starts.size() > 0 && starts[0] + PERIOD <= cyc) void'(starts.pop_front());
  endtask

  // Drive one cycle of event_flag, clock it in, update the model, and
  // leave time 1 unit past the edge for sampling.
  task automatic step(input bit ev);
    event_flag = ev;
    @(posedge clock);
    cyc++;
    model_edge(ev);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      event_flag = i[0];
      @(posedge clock);
      cyc++;
      #1;
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== 5'b1_0_00_0) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, 5'b1_0_00_0);
      end
    end
    event_flag = 1'b0;
    reset_n    = 1'b1;
  endtask

  task automatic test_single_pulse();
    for (int i = 0; i < 8; i++) begin
      step(i == 0);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL single_pulse cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
      // Direct timing: lit for steps 0..2, dark 3..4, idle from 5.
      checks++;
      if ({led_signal, busy} !== {(i >= 3), (i < 5)}) begin
        errors++;
        $display("FAIL single_pulse_timing step=%0d got=%b expected=%b", i,
                 {led_signal, busy}, {(i >= 3), (i < 5)});
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      step(i < 2);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
      if (i == 1) begin
        checks++;
        if (pending !== 2'd1) begin
          errors++;
          $display("FAIL back_to_back_pending got=%0d expected=1", pending);
        end
      end
      if (i < 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back_no_idle step=%0d got=%b expected=1", i, busy);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_count;
    int pulses;
    logic prev_led;
    ovf_count = 0;
    pulses    = 0;
    prev_led  = led_signal;
    for (int i = 0; i < 30; i++) begin
      step(i < 5);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
      if (overflow_flag === 1'b1) ovf_count++;
      if (prev_led === 1'b1 && led_signal === 1'b0) pulses++;
      prev_led = led_signal;
      if (i == 3) begin
        checks++;
        if (pending !== 2'd3) begin
          errors++;
          $display("FAIL overflow_saturate got=%0d expected=3", pending);
        end
      end
    end
    checks++;
    if (ovf_count != 1) begin
      errors++;
      $display("FAIL overflow_pulse_count got=%0d expected=1", ovf_count);
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL overflow_led_pulses got=%0d expected=4", pulses);
    end
  endtask

  task automatic test_full_depth_consume();
    bit pattern [0:5] = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 26; i++) begin
      step((i < 6) ? pattern[i] : 1'b0);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL full_depth cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
      if (i == 5) begin
        checks++;
        if ({led_signal, pending, overflow_flag} !== {1'b0, 2'd3, 1'b0}) begin
          errors++;
          $display("FAIL full_depth_simultaneous got=%b expected=%b",
                   {led_signal, pending, overflow_flag}, {1'b0, 2'd3, 1'b0});
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++;
    if ({led_signal, busy, pending} !== {1'b0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL mid_pulse_setup got=%b expected=%b", {led_signal, busy, pending}, {1'b0, 1'b1, 2'd2});
    end
    event_flag = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({led_signal, busy, pending, overflow_flag} !== 5'b1_0_00_0) begin
      errors++;
      $display("FAIL mid_pulse_async_reset got=%b expected=%b",
               {led_signal, busy, pending, overflow_flag}, 5'b1_0_00_0);
    end
    model_clear();
    @(posedge clock);
    cyc++;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
    end
  endtask

  task automatic test_random();
    bit ev;
    int density;
    for (int i = 0; i < 600; i++) begin
      density = (i / 100) % 3;
      ev = ($urandom_range(0, 5) < (density + 1));
      step(ev);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
    end
    for (int i = 0; i < 25; i++) begin
      step(1'b0);
      checks++;
      if ({led_signal, busy, pending, overflow_flag} !== {exp_led, exp_busy, exp_pend, exp_ovf}) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%b expected=%b", cyc,
                 {led_signal, busy, pending, overflow_flag}, {exp_led, exp_busy, exp_pend, exp_ovf});
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    event_flag = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_overflow();
    test_full_depth_consume();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
